conv_inst_decode: RTL

Instruction decoder for the conv read DMA. It takes the 32-bit instruction stream from the fetch stage and filters packets by target ID. Packets addressed to this engine are assembled into one wide local instruction, which is offered to the DMA core on a start handshake. All other packets are forwarded unchanged through a registered output to the next engine on the instruction chain. Broadcast packets are both captured and forwarded.

---
 rtl/conv_pkg.sv | 21 ++
 rtl/axi_frs.sv | 37 +++
 rtl/conv_inst_decode.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the conv instruction chain: header field
// positions, the broadcast target ID and the decoder FSM state encoding.
package conv_pkg;

  localparam int TID_MSB  = 31;
  localparam int TID_LSB  = 28;
  localparam int PRIO_MSB = 27;
  localparam int PRIO_LSB = 26;
  localparam int LEN_MSB  = 25;
  localparam int LEN_LSB  = 20;

  localparam logic [3:0] BCAST_ID = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAPT = 2'd1,
    FWD  = 2'd2,
    BOTH = 2'd3
  } state_e;

endpackage

// File: rtl/axi_frs.sv
// One-entry forward register slice. The output is fully registered.
// The slice can take a new word in the same cycle that the held word drains.
module axi_frs #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] s_data,
  input  logic          s_valid,
  output logic          s_ready,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready
);

  logic [DW-1:0] data_q;
  logic          valid_q;

  // The slice is free when it is empty or when the held word drains this cycle.
  assign s_ready = !valid_q || m_ready;
  assign m_data  = data_q;
  assign m_valid = valid_q;

  // Load on an accepted input word, otherwise empty the slice on a drain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (s_valid && s_ready) begin
      valid_q <= 1'b1;
      data_q  <= s_data;
    end else if (m_ready) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/conv_inst_decode.sv
// Instruction decoder for the conv read DMA. Packets addressed to this engine
// are captured into the wide local instruction. Other packets are forwarded
// down the chain. Broadcast packets are both captured and forwarded.
module conv_inst_decode
  import conv_pkg::*;
#(
  parameter int         IW  = 32,
  parameter int         DW  = 64,
  parameter int         IN  = 6,
  parameter int         IPW = IN * DW,
  parameter logic [3:0] ID  = 4'h0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [IW-1:0]   inst_m_data,
  input  logic            inst_m_valid,
  output logic            inst_m_ready,
  output logic [IW-1:0]   inst_s_data,
  output logic            inst_s_valid,
  input  logic            inst_s_ready,
  output logic [IPW-1:0]  local_inst,
  output logic [1:0]      start_prior,
  output logic            start_valid,
  input  logic            start_ready
);

  localparam int WPI = IPW / IW;

  state_e      state_q, state_d;
  logic [5:0]  rem_q, rem_d;
  logic [5:0]  idx_q, idx_d;
  logic        start_valid_q, start_valid_d;
  logic [1:0]  prior_q, prior_d;
  logic        fwd_load, cap_clr, cap_wr, frs_free, accept;

  // Header decode. These fields are only acted on in IDLE.
  logic [3:0]  hdr_tid;
  logic [1:0]  hdr_prior;
  logic [5:0]  hdr_len;
  logic        is_match, is_bcast, hdr_cap, hdr_fwd;

  assign hdr_tid   = inst_m_data[TID_MSB:TID_LSB];
  assign hdr_prior = inst_m_data[PRIO_MSB:PRIO_LSB];
  assign hdr_len   = inst_m_data[LEN_MSB:LEN_LSB];
  assign is_match  = (hdr_tid == ID);
  assign is_bcast  = (hdr_tid == BCAST_ID);
  assign hdr_cap   = is_match || is_bcast;
  assign hdr_fwd   = !is_match;

  // Ready depends on state, the pending start and the output slice. It is forced low in reset.
  always_comb begin
    inst_m_ready = 1'b0;
    case (state_q)
      IDLE:    inst_m_ready = (!hdr_cap || !start_valid_q) && (!hdr_fwd || frs_free);
      CAPT:    inst_m_ready = 1'b1;
      FWD:     inst_m_ready = frs_free;
      BOTH:    inst_m_ready = frs_free;
      default: inst_m_ready = 1'b0;
    endcase
    if (!rst_n) inst_m_ready = 1'b0;
  end

  assign accept = inst_m_valid && inst_m_ready;

  // Next-state logic for the packet FSM, the word counters and the start handshake.
  always_comb begin
    state_d       = state_q;
    rem_d         = rem_q;
    idx_d         = idx_q;
    prior_d       = prior_q;
    start_valid_d = start_valid_q;
    fwd_load      = 1'b0;
    cap_clr       = 1'b0;
    cap_wr        = 1'b0;
    if (start_valid_q && start_ready) start_valid_d = 1'b0;
    if (state_q == IDLE) begin
      if (accept) begin
        fwd_load = hdr_fwd;
        rem_d    = hdr_len;
        idx_d    = '0;
        if (hdr_cap) begin
          cap_clr = 1'b1;
          prior_d = hdr_prior;
        end
        if (hdr_len == 6'd0) begin
          if (hdr_cap) start_valid_d = 1'b1;
        end else if (is_match) begin
          state_d = CAPT;
        end else if (is_bcast) begin
          state_d = BOTH;
        end else begin
          state_d = FWD;
        end
      end
    end else if (accept) begin
      rem_d    = rem_q - 6'd1;
      idx_d    = idx_q + 6'd1;
      fwd_load = (state_q != CAPT);
      cap_wr   = (state_q != FWD);
      if (rem_q == 6'd1) begin
        state_d = IDLE;
        if (state_q != FWD) start_valid_d = 1'b1;
      end
    end
  end

  // Register the FSM state, the counters and the start-side outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      rem_q         <= '0;
      idx_q         <= '0;
      prior_q       <= '0;
      start_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rem_q         <= rem_d;
      idx_q         <= idx_d;
      prior_q       <= prior_d;
      start_valid_q <= start_valid_d;
    end
  end

  assign start_valid = start_valid_q;
  assign start_prior = prior_q;

  // One register per local word. Payload beyond WPI matches no word and is dropped.
  genvar gi;
  generate
    for (gi = 0; gi < WPI; gi++) begin : g_word
      logic [IW-1:0] word_q;
      // Clear on a captured header, otherwise load when this word's index comes in.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          word_q <= '0;
        end else if (cap_clr) begin
          word_q <= '0;
        end else if (cap_wr && (int'(idx_q) == gi)) begin
          word_q <= inst_m_data;
        end
      end
      assign local_inst[gi*IW +: IW] = word_q;
    end
  endgenerate

  axi_frs #(.DW(IW)) u_frs (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_data  (inst_m_data),
    .s_valid (fwd_load),
    .s_ready (frs_free),
    .m_data  (inst_s_data),
    .m_valid (inst_s_valid),
    .m_ready (inst_s_ready)
  );

endmodule
